// File: rtl/store_align_if.sv
// Store-path bus bundle between the MEM-stage store logic and the store align unit.
// Ports carried:
//   req_valid/req_ready      store request handshake (requester -> unit)
//   req_addr/size/wdata      byte address, funct3[1:0] size, right-justified data
//   mem_valid/mem_ready      write-beat handshake (unit -> data memory)
//   mem_addr/be/wdata        aligned beat address, byte enables, lane-aligned data
//   misalign_fault, busy     status from the unit
// slave modport is the unit's view; master is the surrounding pipeline/memory view.
interface store_align_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              misalign_fault;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_be, mem_wdata, misalign_fault, busy
  );

  modport master (
    output req_valid, req_addr, req_size, req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata, misalign_fault, busy
  );
endinterface

// File: rtl/store_align_unit.sv
// Store align unit: takes one store per req handshake and emits registered,
// word-aligned write beats. A store that crosses a bus-word boundary becomes two
// beats (MISALIGN_EN=1) or is rejected with a one-cycle misalign_fault pulse.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   store_align_if.slave (request side, memory beat side, status)
//
// state | meaning
// IDLE  | no beat outstanding, req_ready high
// BEAT0 | first (or only) beat presented on the memory port
// BEAT1 | high half of a boundary-crossing store presented
module store_align_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  store_align_if.slave  bus
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int MW   = 2 * NB;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state, state_nxt;
  logic              valid_q, valid_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [NB-1:0]     be_q, be_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [NB-1:0]     hi_be_q, hi_be_nxt;
  logic [DATA_W-1:0] hi_wdata_q, hi_wdata_nxt;
  logic              fault_q, fault_nxt;

  logic [OFFW-1:0]     off;
  logic [3:0]          nbytes;
  logic                size_bad;
  logic                align_bad;
  logic [MW-1:0]       mask2;
  logic [2*DATA_W-1:0] data2;

  // Two-word-wide view of the store: low half is beat 0, high half is beat 1.
  always_comb begin
    off       = bus.req_addr[OFFW-1:0];
    nbytes    = 4'd1 << bus.req_size;
    size_bad  = int'(nbytes) > NB;
    align_bad = !MISALIGN_EN && ((4'(off) & (nbytes - 4'd1)) != 4'd0);
    mask2     = MW'((16'd1 << nbytes) - 16'd1) << off;
    data2     = {{DATA_W{1'b0}}, bus.req_wdata} << {off, 3'b000};
    // Requester need not zero bits above the store size; clear unenabled lanes.
    for (int i = 0; i < MW; i++) begin
      if (!mask2[i]) data2[8*i +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_nxt    = state;
    valid_nxt    = valid_q;
    addr_nxt     = addr_q;
    be_nxt       = be_q;
    wdata_nxt    = wdata_q;
    hi_be_nxt    = hi_be_q;
    hi_wdata_nxt = hi_wdata_q;
    fault_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (size_bad || align_bad) begin
            fault_nxt = 1'b1;
          end else begin
            state_nxt    = BEAT0;
            valid_nxt    = 1'b1;
            addr_nxt     = {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            be_nxt       = mask2[NB-1:0];
            wdata_nxt    = data2[DATA_W-1:0];
            hi_be_nxt    = mask2[MW-1:NB];
            hi_wdata_nxt = data2[2*DATA_W-1:DATA_W];
          end
        end
      end
      BEAT0: begin
        if (bus.mem_ready) begin
          if (|hi_be_q) begin
            state_nxt = BEAT1;
            addr_nxt  = addr_q + ADDR_W'(NB);
            be_nxt    = hi_be_q;
            wdata_nxt = hi_wdata_q;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            be_nxt    = '0;
            wdata_nxt = '0;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          be_nxt    = '0;
          wdata_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        be_nxt    = '0;
        wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid_q    <= valid_nxt;
      addr_q     <= addr_nxt;
      be_q       <= be_nxt;
      wdata_q    <= wdata_nxt;
      hi_be_q    <= hi_be_nxt;
      hi_wdata_q <= hi_wdata_nxt;
      fault_q    <= fault_nxt;
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.mem_valid      = valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_be         = be_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.misalign_fault = fault_q;
endmodule
